// File: rtl/instr_fetch_pkg.sv
// Shared CPU constants used by the fetch stage: global state codes and bus sizes.
package instr_fetch_pkg;

   localparam int STATE_SIZE0 = 3;
   localparam int ADDR_SIZE0  = 31;
   localparam int DATA_SIZE0  = 31;
   localparam int CMD_W       = 32;

   localparam logic [STATE_SIZE0:0] ST_RESET  = 4'd0;
   localparam logic [STATE_SIZE0:0] FETCH_CMD = 4'd1;
   localparam logic [STATE_SIZE0:0] FETCH_OPS = 4'd2;
   localparam logic [STATE_SIZE0:0] EXECUTE   = 4'd3;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Bus wait counter: counts enabled cycles and flags expiry on the LIMIT-th one.
module bus_timeout_cnt #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + 1'b1;
   end

   assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Command-word fetch stage: reads one word at base_addr+ip per FETCH_CMD visit.
// Optional bus timeout with sticky fault is built when BUS_TIMEOUT_EN is defined.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_W         = ADDR_SIZE0 + 1,
   parameter int DATA_W         = DATA_SIZE0 + 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [STATE_SIZE0:0] state,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic                 is_bus_busy,
   input  logic                 read_dn,
   input  logic [DATA_W-1:0]    data,
   input  logic                 jmp_en,
   input  logic [ADDR_W-1:0]    jmp_addr,
   output logic [ADDR_W-1:0]    addr,
   output logic                 read_q,
   output logic [CMD_W-1:0]     command_word,
   output logic [ADDR_W-1:0]    ip,
   output logic                 next_state,
   output logic                 fault
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BUS = 2'd1,
      REQ      = 2'd2,
      DONE     = 2'd3
   } fetch_st_t;

   fetch_st_t        st, st_nxt;
   logic [ADDR_W-1:0] addr_r;
   logic             fetch_cmd;
   logic             got_word;
   logic             tmo;
   logic             unused_data;

   assign fetch_cmd   = (state == FETCH_CMD);
   // A response only counts once the request is actually on the bus.
   assign got_word    = read_q && read_dn;
   assign unused_data = ^data;

`ifdef BUS_TIMEOUT_EN
   logic fault_r;

   bus_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (st != REQ),
      .en      ((st == REQ) && fetch_cmd && !got_word),
      .expired (tmo)
   );

   always_ff @(posedge clk) begin
      if (rst)
         fault_r <= 1'b0;
      else if (st == REQ && fetch_cmd && !got_word && tmo)
         fault_r <= 1'b1;
   end

   assign fault = fault_r;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;

   assign tmo   = 1'b0;
   assign fault = 1'b0;
`endif

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      st_nxt = st;
      unique case (st)
         IDLE: begin
            if (!jmp_en && fetch_cmd) begin
               if (is_bus_busy == 1'b1) st_nxt = WAIT_BUS;
               else                     st_nxt = REQ;
            end
         end
         WAIT_BUS: begin
            if (!fetch_cmd)               st_nxt = IDLE;
            else if (is_bus_busy == 1'b1) st_nxt = WAIT_BUS;
            else                          st_nxt = REQ;
         end
         REQ: begin
            if (!fetch_cmd)           st_nxt = IDLE;
            else if (got_word || tmo) st_nxt = DONE;
         end
         DONE: begin
            if (!fetch_cmd) st_nxt = IDLE;
         end
         default: st_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         st           <= IDLE;
         ip           <= '0;
         command_word <= '0;
         read_q       <= 1'b0;
         addr_r       <= '0;
         next_state   <= 1'b0;
      end else begin
         st         <= st_nxt;
         next_state <= 1'b0;
         unique case (st)
            IDLE: begin
               read_q <= 1'b0;
               if (jmp_en) ip <= jmp_addr;
            end
            REQ: begin
               if (!fetch_cmd) begin
                  read_q <= 1'b0;
               end else if (got_word) begin
                  command_word <= data[CMD_W-1:0];
                  ip           <= ip + 1'b1;
                  read_q       <= 1'b0;
                  next_state   <= 1'b1;
               end else if (tmo) begin
                  command_word <= '0;
                  read_q       <= 1'b0;
                  next_state   <= 1'b1;
               end else begin
                  read_q <= 1'b1;
                  addr_r <= base_addr + ip;
               end
            end
            default: read_q <= 1'b0;
         endcase
      end
   end

   assign addr = read_q ? addr_r : {ADDR_W{1'bz}};

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a negedge memory responder.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   logic        clk;
   logic        rst;
   logic [3:0]  state;
   logic [31:0] base_addr;
   logic        is_bus_busy;
   logic        read_dn;
   logic [31:0] data;
   logic        jmp_en;
   logic [31:0] jmp_addr;
   wire  [31:0] addr;
   logic        read_q;
   logic [31:0] command_word;
   logic [31:0] ip;
   logic        next_state;
   logic        fault;

   logic        dn_resp, dn_force;
   logic        resp_on;
   int          extra_wait;
   int          pulse_cnt;
   int          total, bad;

   assign read_dn = dn_resp | dn_force;

   instr_fetch #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .state        (state),
      .base_addr    (base_addr),
      .is_bus_busy  (is_bus_busy),
      .read_dn      (read_dn),
      .data         (data),
      .jmp_en       (jmp_en),
      .jmp_addr     (jmp_addr),
      .addr         (addr),
      .read_q       (read_q),
      .command_word (command_word),
      .ip           (ip),
      .next_state   (next_state),
      .fault        (fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h10) return 32'h0013_F742;
      return a ^ 32'h5A00_00C3;
   endfunction

   // Memory responder: answers on the negedge after extra_wait request cycles.
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      dn_resp  = 1'b0;
      data     = '0;
      forever begin
         @(negedge clk);
         dn_resp = 1'b0;
         if (resp_on && read_q && !rst) begin
            if (wait_cnt >= extra_wait) begin
               dn_resp  = 1'b1;
               data     = mem_word(addr);
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      pulse_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (next_state) pulse_cnt++;
      end
   end

   task automatic leave_fetch(input int n);
      state  = FETCH_OPS;
      jmp_en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Starts a fetch at a negedge and returns at the negedge where next_state is seen.
   task automatic do_fetch(input int busy, input logic jmp, input logic [31:0] jaddr,
                           output int lat, output logic rq_ok, output logic [31:0] seen_addr);
      lat         = -1;
      rq_ok       = 1'b1;
      seen_addr   = '0;
      state       = FETCH_CMD;
      is_bus_busy = (busy > 0);
      jmp_en      = jmp;
      jmp_addr    = jaddr;
      for (int cyc = 0; cyc < 64; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         jmp_en = 1'b0;
         if (cyc < busy && read_q) rq_ok = 1'b0;
         if (cyc == busy - 1) is_bus_busy = 1'b0;
         if (read_q) seen_addr = addr;
         if (next_state) begin
            lat = cyc;
            break;
         end
      end
      is_bus_busy = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (read_q !== 1'b0) begin bad++; $display("FAIL reset_read_q got=%0b want=0", read_q); end
      total++; if (ip !== 32'h0) begin bad++; $display("FAIL reset_ip got=%h want=0", ip); end
      total++; if (command_word !== 32'h0) begin bad++; $display("FAIL reset_cw got=%h want=0", command_word); end
      total++; if (next_state !== 1'b0) begin bad++; $display("FAIL reset_next_state got=%0b want=0", next_state); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b want=0", fault); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_fetch;
      int lat; logic rq_ok; logic [31:0] sa; int p0; logic held_low;
      base_addr = 32'h10; resp_on = 1'b1; extra_wait = 0;
      p0 = pulse_cnt;
      do_fetch(0, 1'b0, '0, lat, rq_ok, sa);
      total++; if (lat != 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", lat); end
      total++; if (sa !== 32'h10) begin bad++; $display("FAIL basic_addr got=%h want=00000010", sa); end
      total++; if (command_word !== 32'h0013_F742) begin bad++; $display("FAIL basic_cw got=%h want=0013f742", command_word); end
      total++; if (ip !== 32'h1) begin bad++; $display("FAIL basic_ip got=%h want=1", ip); end
      held_low = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (read_q !== 1'b0) held_low = 1'b0;
      end
      total++; if (held_low !== 1'b1) begin bad++; $display("FAIL done_no_refetch got=%0b want=1", held_low); end
      leave_fetch(2);
      total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL basic_pulses got=%0d want=1", pulse_cnt - p0); end
   endtask

   task automatic test_bus_busy;
      int lat; logic rq_ok; logic [31:0] sa;
      do_fetch(3, 1'b0, '0, lat, rq_ok, sa);
      total++; if (lat != 5) begin bad++; $display("FAIL busy_latency got=%0d want=5", lat); end
      total++; if (rq_ok !== 1'b1) begin bad++; $display("FAIL busy_read_q_low got=%0b want=1", rq_ok); end
      total++; if (sa !== 32'h11) begin bad++; $display("FAIL busy_addr got=%h want=00000011", sa); end
      total++; if (command_word !== 32'h5A00_00D2) begin bad++; $display("FAIL busy_cw got=%h want=5a0000d2", command_word); end
      total++; if (ip !== 32'h2) begin bad++; $display("FAIL busy_ip got=%h want=2", ip); end
      leave_fetch(2);
   endtask

   task automatic test_jump;
      int lat; logic rq_ok; logic [31:0] sa;
      do_fetch(0, 1'b1, 32'h20, lat, rq_ok, sa);
      total++; if (lat != 3) begin bad++; $display("FAIL jump_latency got=%0d want=3", lat); end
      total++; if (sa !== 32'h30) begin bad++; $display("FAIL jump_addr got=%h want=00000030", sa); end
      total++; if (ip !== 32'h21) begin bad++; $display("FAIL jump_ip got=%h want=21", ip); end
      jmp_en = 1'b1; jmp_addr = 32'h99;
      @(negedge clk);
      jmp_en = 1'b0;
      @(negedge clk);
      total++; if (ip !== 32'h21) begin bad++; $display("FAIL jump_ignored_in_done got=%h want=21", ip); end
      leave_fetch(2);
   endtask

   task automatic test_wrap;
      int lat; logic rq_ok; logic [31:0] sa;
      base_addr = 32'h0;
      do_fetch(0, 1'b1, 32'hFFFF_FFFF, lat, rq_ok, sa);
      total++; if (sa !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_addr got=%h want=ffffffff", sa); end
      total++; if (ip !== 32'h0) begin bad++; $display("FAIL wrap_ip got=%h want=0", ip); end
      leave_fetch(2);
      base_addr = 32'h10;
      do_fetch(0, 1'b1, 32'hFFFF_FFF8, lat, rq_ok, sa);
      total++; if (sa !== 32'h8) begin bad++; $display("FAIL sum_wrap_addr got=%h want=00000008", sa); end
      total++; if (command_word !== 32'h5A00_00CB) begin bad++; $display("FAIL sum_wrap_cw got=%h want=5a0000cb", command_word); end
      total++; if (ip !== 32'hFFFF_FFF9) begin bad++; $display("FAIL sum_wrap_ip got=%h want=fffffff9", ip); end
      leave_fetch(2);
   endtask

   task automatic test_back_to_back;
      int lat; logic rq_ok; logic [31:0] sa;
      base_addr = 32'h40; extra_wait = 2;
      do_fetch(0, 1'b1, 32'h100, lat, rq_ok, sa);
      total++; if (lat != 5) begin bad++; $display("FAIL b2b_slow_latency got=%0d want=5", lat); end
      total++; if (sa !== 32'h140) begin bad++; $display("FAIL b2b_slow_addr got=%h want=00000140", sa); end
      total++; if (ip !== 32'h101) begin bad++; $display("FAIL b2b_slow_ip got=%h want=101", ip); end
      leave_fetch(1);
      extra_wait = 0;
      do_fetch(0, 1'b0, '0, lat, rq_ok, sa);
      total++; if (lat != 2) begin bad++; $display("FAIL b2b_fast_latency got=%0d want=2", lat); end
      total++; if (command_word !== 32'h5A00_0182) begin bad++; $display("FAIL b2b_fast_cw got=%h want=5a000182", command_word); end
      total++; if (ip !== 32'h102) begin bad++; $display("FAIL b2b_fast_ip got=%h want=102", ip); end
      leave_fetch(2);
   endtask

   task automatic test_abort;
      int p0; logic seen;
      resp_on = 1'b0; p0 = pulse_cnt; seen = 1'b0;
      state = FETCH_CMD;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = read_q;
      end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL abort_req_seen got=%0b want=1", seen); end
      state = FETCH_OPS;
      @(negedge clk);
      total++; if (read_q !== 1'b0) begin bad++; $display("FAIL abort_read_q got=%0b want=0", read_q); end
      repeat (3) @(negedge clk);
      total++; if (ip !== 32'h102) begin bad++; $display("FAIL abort_ip got=%h want=102", ip); end
      total++; if (command_word !== 32'h5A00_0182) begin bad++; $display("FAIL abort_cw got=%h want=5a000182", command_word); end
      total++; if (pulse_cnt != p0) begin bad++; $display("FAIL abort_pulses got=%0d want=0", pulse_cnt - p0); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL abort_fault got=%0b want=0", fault); end
   endtask

   task automatic test_reset_mid_req;
      int p0; logic seen;
      resp_on = 1'b0; p0 = pulse_cnt; seen = 1'b0;
      state = FETCH_CMD;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = read_q;
      end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstreq_req_seen got=%0b want=1", seen); end
      rst = 1'b1; dn_force = 1'b1; data = 32'hDEAD_BEEF; state = FETCH_OPS;
      @(negedge clk);
      total++; if (read_q !== 1'b0) begin bad++; $display("FAIL rstreq_read_q got=%0b want=0", read_q); end
      total++; if (ip !== 32'h0) begin bad++; $display("FAIL rstreq_ip got=%h want=0", ip); end
      total++; if (command_word !== 32'h0) begin bad++; $display("FAIL rstreq_cw got=%h want=0", command_word); end
      rst = 1'b0; dn_force = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (pulse_cnt != p0) begin bad++; $display("FAIL rstreq_pulses got=%0d want=0", pulse_cnt - p0); end
   endtask

`ifdef BUS_TIMEOUT_EN
   task automatic test_timeout;
      int lat; logic rq_ok; logic [31:0] sa; int p0;
      base_addr = 32'h10; resp_on = 1'b1; extra_wait = 0;
      do_fetch(0, 1'b0, '0, lat, rq_ok, sa);
      leave_fetch(2);
      resp_on = 1'b0; p0 = pulse_cnt;
      do_fetch(0, 1'b0, '0, lat, rq_ok, sa);
      total++; if (lat != 16) begin bad++; $display("FAIL tmo_latency got=%0d want=16", lat); end
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL tmo_fault got=%0b want=1", fault); end
      total++; if (command_word !== 32'h0) begin bad++; $display("FAIL tmo_cw got=%h want=0", command_word); end
      total++; if (ip !== 32'h1) begin bad++; $display("FAIL tmo_ip got=%h want=1", ip); end
      leave_fetch(3);
      total++; if (read_q !== 1'b0) begin bad++; $display("FAIL tmo_read_q got=%0b want=0", read_q); end
      total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL tmo_pulses got=%0d want=1", pulse_cnt - p0); end
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL tmo_fault_sticky got=%0b want=1", fault); end
   endtask
`endif

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; state = ST_RESET; base_addr = '0; is_bus_busy = 1'b0;
      jmp_en = 1'b0; jmp_addr = '0; dn_force = 1'b0; resp_on = 1'b0; extra_wait = 0;
      @(negedge clk);
      test_reset;
      test_basic_fetch;
      test_bus_busy;
      test_jump;
      test_wrap;
      test_back_to_back;
      test_abort;
      test_reset_mid_req;
`ifdef BUS_TIMEOUT_EN
      test_timeout;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Command-word fetch stage, directly upstream of the operand memory manager. During the command-fetch state it reads one 32-bit command word from memory at `base_addr + ip` over the shared request/done bus. It latches the word onto `command_word` for the operand stage, advances the instruction pointer, and pulses `next_state` to the state manager. A jump input reloads the instruction pointer between fetches.

## Interface
Parameters:
- `ADDR_W`, default `ADDR_SIZE0+1` (32): address and instruction-pointer width.
- `DATA_W`, default `DATA_SIZE0+1` (32): bus data width; the command word is the low 32 bits.
- `TIMEOUT_CYCLES`, default 16: bus wait limit; used only with `BUS_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: reset, synchronous and active-high.
- `state` in `STATE_SIZE0+1`: global CPU state from the state manager.
- `base_addr` in `ADDR_W`: program base address.
- `is_bus_busy` in 1: shared bus-busy line; only `1'b1` means busy, and `z`/`0` mean free.
- `read_dn` in 1: read done from the memory responder.
- `data` in `DATA_W`: read data, valid while `read_dn`=1.
- `jmp_en` in 1: load the instruction pointer.
- `jmp_addr` in `ADDR_W`: new instruction-pointer value.
- `addr` out `ADDR_W`: bus address; `z` when no request is active.
- `read_q` out 1: read request.
- `command_word` out 32: last fetched command word.
- `ip` out `ADDR_W`: current instruction pointer, as a word offset.
- `next_state` out 1: one-cycle pulse marking fetch complete.
- `fault` out 1: sticky bus-timeout flag; constant 0 without `BUS_TIMEOUT_EN`.

## Operation
FSM with four states: IDLE, WAIT_BUS, REQ, DONE.
- IDLE, when `state`==`FETCH_CMD`:
  - If `is_bus_busy`=1, go to WAIT_BUS.
  - Otherwise, go to REQ.
- IDLE, when `jmp_en`=1: `ip` <= `jmp_addr`. This takes priority over the fetch start in the same cycle; the fetch begins the following cycle using the new `ip`.
- `jmp_en` is ignored outside IDLE.
- WAIT_BUS: stay while `is_bus_busy`=1, then go to REQ.
- REQ: `read_q`=1 and `addr`=`base_addr + ip`, with the sum taken modulo 2^`ADDR_W`.
- REQ, on sampling `read_dn`=1:
  - `command_word` <= `data[31:0]` and `ip` <= `ip+1`, which wraps from all-ones to 0.
  - `read_q` <= 0 and `addr` <= `z`.
  - `next_state` is pulsed for one cycle; go to DONE.
- DONE: hold until `state` != `FETCH_CMD`, then go to IDLE. This guarantees exactly one fetch per state visit.
- `state` leaving `FETCH_CMD` while the FSM is in WAIT_BUS or REQ: abort. Go to IDLE, drop `read_q`, and leave `ip` and `command_word` unchanged.
- Reset values:
  - FSM=IDLE, `ip`=0, `command_word`=0.
  - `read_q`=0, `addr`=`z`, `next_state`=0, `fault`=0.
- Reset asserted mid-request: `read_q` falls at that edge, and any `read_dn` in the same cycle is ignored.

## Timing
- All outputs are registered.
- Edge N samples `state`==`FETCH_CMD` with the bus free; `read_q` and `addr` become valid after edge N+1.
- The responder answers on the negedge, so `read_dn` is sampled at edge N+2. `command_word`, `ip+1` and the `next_state` pulse are then visible after N+2.
- Minimum latency is 2 cycles; each busy cycle in WAIT_BUS and each extra `read_dn` wait adds 1 cycle.
- `read_q` stays high until `read_dn` is sampled; it is never retracted early except on abort or reset.
- `next_state` is high for exactly one cycle per completed fetch.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - A counter runs in REQ.
  - After `TIMEOUT_CYCLES` cycles without `read_dn`: drop `read_q`, set `command_word`=0 (NOP), leave `ip` unchanged, set `fault`=1, pulse `next_state`, and go to DONE.
  - `fault` clears only on `rst`.
- `BUS_TIMEOUT_EN` undefined: REQ waits indefinitely, no counter is built, and `fault` is tied to 0.

## Structure
- Shared package (`states.v`): the `FETCH_CMD` state code and `STATE_SIZE0`.
- Shared package (`sizes.v`): `ADDR_SIZE0` and `DATA_SIZE0`.
- FSM encodings are local parameters.
- Natural sub-module: `bus_timeout_cnt`, a counter with clear/enable and an expired output, instantiated only under `BUS_TIMEOUT_EN`.

## Test plan
- Reset, `base_addr`=0x10, memory[0x10]=0x0013_F742, enter `FETCH_CMD`, `read_dn` after 1 cycle -> `command_word`=0x0013_F742, `ip`=1, one `next_state` pulse, latency 2 cycles.
- `is_bus_busy`=1 for 3 cycles at fetch start -> `read_q` stays 0 for 3 cycles, then the fetch completes; latency 5 cycles.
- `jmp_en`=1 with `jmp_addr`=0x20 in the same cycle as the fetch start -> `addr`=`base_addr`+0x20, `ip`=0x21 afterwards.
- `ip`=0xFFFF_FFFF, `base_addr`=0 -> `addr`=0xFFFF_FFFF, and `ip` wraps to 0 after the fetch.
- `rst` while `read_q`=1 -> `read_q`=0, `addr`=`z`, `ip`=0 after that edge, and no `next_state` pulse.
- `BUS_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16 and no `read_dn` -> after 16 REQ cycles `fault`=1, `command_word`=0, `ip` unchanged, one `next_state` pulse.
